// File: rtl/correlator_bank.sv
// correlator_bank: multi-tap sign-magnitude correlator with saturating accumulators, epoch dump handshake and overrun counting
module correlator_bank #(
  parameter int NUM_TAPS  = 3,
  parameter int ACC_WIDTH = 19,
  parameter int OVR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sample_en,
  input  logic [2:0]                    data,
  input  logic [NUM_TAPS-1:0]           tap_code,
  input  logic                          epoch,
  input  logic                          dump_ready,
  output logic                          dump_valid,
  output logic [NUM_TAPS*ACC_WIDTH-1:0] dump_data,
  output logic [NUM_TAPS-1:0]           dump_sat,
  output logic                          overrun,
  output logic [OVR_WIDTH-1:0]          overrun_count
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic signed [ACC_WIDTH:0] MAXV = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = -MAXV;
  logic [0:0] state;
  logic [NUM_TAPS-1:0][ACC_WIDTH-1:0] acc, nxt;
  logic [NUM_TAPS-1:0] sat, nxt_sat;
  logic signed [ACC_WIDTH:0] mag, sum;
  logic run, ep, xfer;
  assign mag  = {{(ACC_WIDTH-2){1'b0}}, data[1:0], 1'b1};
  assign run  = (state == RUN) && enable;
  assign ep   = run & sample_en & epoch;
  assign xfer = ep & (~dump_valid | dump_ready);
  // one extra bit of headroom so the clamp can see the overflow before truncation
  always_comb begin
    nxt = '0;
    nxt_sat = '0;
    sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      sum = $signed({acc[i][ACC_WIDTH-1], acc[i]}) + ((data[2] ^ ~tap_code[i]) ? -mag : mag);
      nxt[i] = (sum > MAXV) ? MAXV[ACC_WIDTH-1:0] : (sum < MINV) ? MINV[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
      nxt_sat[i] = sat[i] | (sum > MAXV) | (sum < MINV);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      sat           <= '0;
      dump_valid    <= 1'b0;
      dump_data     <= '0;
      dump_sat      <= '0;
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else begin
      state <= enable ? RUN : IDLE;
      if (!run || ep) begin
        acc <= '0;
        sat <= '0;
      end else if (sample_en) begin
        acc <= nxt;
        sat <= nxt_sat;
      end
      if (xfer) begin
        dump_data <= nxt;
        dump_sat  <= nxt_sat;
      end
      dump_valid <= xfer | (dump_valid & ~dump_ready);
      if (ep & ~xfer) begin
        overrun       <= 1'b1;
        overrun_count <= overrun_count + {{(OVR_WIDTH-1){1'b0}}, ~&overrun_count};
      end
    end
  end
endmodule

// File: tb/tb_correlator_bank.sv
// tb_correlator_bank: scoreboard bench for correlator_bank at default width and at ACC_WIDTH=8
module tb_correlator_bank;
  logic clk = 0, reset = 1, enable = 0, sample_en = 0, epoch = 0, dump_ready = 1;
  logic [2:0] data = 0, tap_code = 0;
  logic dv, ov, dv8, ov8;
  logic [56:0] dd;
  logic [23:0] dd8;
  logic [2:0] ds, ds8;
  logic [7:0] oc, oc8;
  int total = 0, bad = 0;
  int m[3], m8[3], mov;
  logic [2:0] s, s8;
  bit mrun, mvalid;
  logic [59:0] q[$];
  logic [26:0] q8[$];

  always #5 clk = ~clk;

  correlator_bank u_dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en), .data(data),
    .tap_code(tap_code), .epoch(epoch), .dump_ready(dump_ready), .dump_valid(dv),
    .dump_data(dd), .dump_sat(ds), .overrun(ov), .overrun_count(oc));

  correlator_bank #(.ACC_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en), .data(data),
    .tap_code(tap_code), .epoch(epoch), .dump_ready(dump_ready), .dump_valid(dv8),
    .dump_data(dd8), .dump_sat(ds8), .overrun(ov8), .overrun_count(oc8));

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      m[i] = 0;
      m8[i] = 0;
    end
    s = 0;
    s8 = 0;
  endtask

  // reference model steps in lockstep with the clock edge the DUT is about to take
  task automatic tick();
    logic [56:0] e;
    logic [23:0] e8;
    bit push;
    push = 0;
    e = 0;
    e8 = 0;
    if (reset) begin
      clear_model();
      mrun = 0;
      mvalid = 0;
      mov = 0;
      q.delete();
      q8.delete();
    end else begin
      if (mrun && enable && sample_en) begin
        for (int i = 0; i < 3; i++) begin
          int p;
          p = 2 * int'(data[1:0]) + 1;
          if (data[2] ^ !tap_code[i]) p = -p;
          m[i] += p;
          if (m[i] > 262143) begin m[i] = 262143; s[i] = 1; end
          if (m[i] < -262143) begin m[i] = -262143; s[i] = 1; end
          m8[i] += p;
          if (m8[i] > 127) begin m8[i] = 127; s8[i] = 1; end
          if (m8[i] < -127) begin m8[i] = -127; s8[i] = 1; end
          e[i*19 +: 19] = m[i][18:0];
          e8[i*8 +: 8] = m8[i][7:0];
        end
        if (epoch) begin
          if (!mvalid || dump_ready) begin
            q.push_back({s, e});
            q8.push_back({s8, e8});
            push = 1;
          end else if (mov < 255) mov++;
          clear_model();
        end
      end
      if (!(mrun && enable)) clear_model();
      mvalid = push || (mvalid && !dump_ready);
      mrun = enable;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic smp(logic [2:0] d, logic [2:0] tc, logic ep);
    sample_en = 1;
    data = d;
    tap_code = tc;
    epoch = ep;
    tick();
    sample_en = 0;
    epoch = 0;
  endtask

  task automatic run_epoch(int n, logic [2:0] d, logic [2:0] tc);
    for (int i = 1; i < n; i++) smp(d, tc, 0);
    smp(d, tc, 1);
  endtask

  task automatic chk_stat(string tag);
    check({tag, "_dv"}, dv, mvalid);
    check({tag, "_ov"}, ov, mov > 0);
    check({tag, "_oc"}, oc, mov);
  endtask

  always @(negedge clk) begin
    logic [59:0] x;
    logic [26:0] x8;
    if (!reset && dv && dump_ready) begin
      check("dv8", dv8, dv);
      check("ovr8", {ov8, oc8}, {ov, oc});
      if (q.size() == 0 || q8.size() == 0) check("q_empty", q.size(), 1);
      else begin
        x = q.pop_front();
        x8 = q8.pop_front();
        check("dump", {ds, dd}, x);
        check("dump8", {ds8, dd8}, x8);
      end
    end
  end

  initial begin
    tick();
    tick();
    check("rst_dv", dv, 0);
    check("rst_dd", dd, 0);
    check("rst_ds", ds, 0);
    check("rst_ov", ov, 0);
    check("rst_oc", oc, 0);
    reset = 0;
    enable = 1;
    tick();
    run_epoch(1023, 3'b011, 3'b111);
    check("r33_dv", dv, 1);
    check("r33_dd", dd, {3{19'd7161}});
    check("r33_ds", ds, 0);
    tick();
    run_epoch(1023, 3'b100, 3'b010);
    check("r34_tap0", dd[0 +: 19], 19'd1023);
    check("r34_tap1", dd[19 +: 19], 19'h7fc01);
    tick();
    run_epoch(20, 3'b011, 3'b111);
    check("r35_dd8", dd8, {3{8'd127}});
    check("r35_ds8", ds8, 3'b111);
    run_epoch(1, 3'b000, 3'b111);
    check("r35_dd8b", dd8, {3{8'd1}});
    check("r35_ds8b", ds8, 3'b000);
    tick();
    dump_ready = 0;
    run_epoch(1, 3'b001, 3'b111);
    run_epoch(1, 3'b010, 3'b111);
    run_epoch(1, 3'b011, 3'b111);
    check("r36_held", dd, {3{19'd3}});
    check("r36_ov", ov, 1);
    check("r36_oc", oc, 2);
    dump_ready = 1;
    run_epoch(1, 3'b111, 3'b111);
    check("r36_dv", dv, 1);
    check("r36_new", dd, {3{19'h7fff9}});
    chk_stat("r36");
    tick();
    dump_ready = 0;
    run_epoch(1, 3'b001, 3'b111);
    for (int i = 0; i < 500; i++) smp(3'b011, 3'b101, 0);
    enable = 0;
    tick();
    tick();
    check("r37_dv", dv, 1);
    check("r37_dd", dd, {3{19'd3}});
    enable = 1;
    tick();
    dump_ready = 1;
    run_epoch(10, 3'b000, 3'b111);
    check("r37_sum", dd, {3{19'd10}});
    chk_stat("r37");
    dump_ready = 0;
    for (int i = 0; i < 3; i++) run_epoch(1, 3'b010, 3'b011);
    check("r38_oc", oc, 5);
    chk_stat("r38pre");
    reset = 1;
    sample_en = 1;
    data = 3'b011;
    tap_code = 3'b111;
    epoch = 1;
    tick();
    reset = 0;
    check("r38_dv", dv, 0);
    check("r38_dd", dd, 0);
    check("r38_ds", ds, 0);
    check("r38_ov", ov, 0);
    check("r38_oc", oc, 0);
    tick();
    sample_en = 0;
    epoch = 0;
    check("r38_idle", dv, 0);
    dump_ready = 1;
    run_epoch(1, 3'b001, 3'b111);
    check("r38_first", dd, {3{19'd3}});
    tick();
    tick();
    chk_stat("end");
    check("q_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/correlator_bank.md
CORRELATOR_BANK -- requirements
Module: correlator_bank

Interface
REQ-001 Parameter NUM_TAPS, default 3, number of correlator taps (e.g. early/prompt/late), range 1..8.
REQ-002 Parameter ACC_WIDTH, default 19, signed accumulator width per tap, range 8..32.
REQ-003 Parameter OVR_WIDTH, default 8, width of the dropped-dump counter.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high = correlate; low = accumulators held at zero.
REQ-007 sample_en  input  1  one-cycle strobe; data and tap_code are valid this cycle.
REQ-008 data  input  3  GPS sample, sign-magnitude {sign, mag[1:0]}.
REQ-009 tap_code  input  NUM_TAPS  replica C/A bit per tap, aligned with data.
REQ-010 epoch  input  1  qualified by sample_en; marks the last sample of a code period.
REQ-011 dump_ready  input  1  consumer accepts dump_data.
REQ-012 dump_valid  output  1  dump_data holds an unconsumed epoch result.
REQ-013 dump_data  output  NUM_TAPS*ACC_WIDTH  per-tap sums; tap i in bits [i*ACC_WIDTH +: ACC_WIDTH].
REQ-014 dump_sat  output  NUM_TAPS  per tap, set if that tap saturated during the dumped epoch.
REQ-015 overrun  output  1  sticky flag: at least one epoch result was dropped.
REQ-016 overrun_count  output  OVR_WIDTH  number of dropped epochs, saturating.

Function
REQ-017 Sample value = (2*mag+1) with the sign applied; sign=1 is negative. The set of values is {±1, ±3, ±5, ±7}.
REQ-018 Product per tap: tap_code=1 gives +value; tap_code=0 gives -value.
REQ-019 Accumulation on enable & sample_en: acc[i] <= sat(acc[i] + product[i]). The sum is visible the next cycle.
REQ-020 Saturation limits are +(2^(ACC_WIDTH-1)-1) and -(2^(ACC_WIDTH-1)-1).
  - Clamping sets an internal sat flag for that tap.
  - The sat flag clears when the epoch is transferred or dropped.
REQ-021 FSM has two states, IDLE and RUN.
  - IDLE to RUN when enable=1.
  - RUN to IDLE when enable=0.
  - In IDLE, accumulators and sat flags are forced to 0 and sample_en is ignored.
REQ-022 Epoch in RUN (epoch & sample_en): the epoch sample is included in the sum.
  - The included sum is offered for transfer to dump_data/dump_sat.
  - acc[i] restarts at 0, so the next sample's sum is just that sample.
REQ-023 Transfer occurs if dump_valid=0 or dump_ready=1 in the epoch cycle.
  - dump_valid=1 from the next cycle, holding the epoch-inclusive sums.
  - Latency is 1 cycle from the epoch strobe.
REQ-024 Transfer is blocked (dump_valid=1, dump_ready=0): the new result is dropped.
  - Existing dump_data is unchanged.
  - overrun is set.
  - overrun_count increments and saturates at all-ones.
REQ-025 Handshake completes when dump_valid & dump_ready. dump_valid falls the next cycle unless REQ-023 reloads it in the same cycle, in which case dump_valid stays 1 with new data.
REQ-026 dump_data, dump_sat and dump_valid are stable while dump_valid=1 and dump_ready=0.
REQ-027 enable falling mid-epoch discards the partial sums. A pending dump (dump_valid=1) is retained and can still be consumed.
REQ-028 sample_en with epoch=0 in IDLE has no effect. epoch without sample_en is ignored.
REQ-029 All outputs are registered. There is no combinational path from any input to any output.

Reset
REQ-030 On reset=1 at a clk edge: FSM goes to IDLE, all accumulators and sat flags are 0, dump_valid=0, dump_data=0, dump_sat=0, overrun=0, overrun_count=0.
REQ-031 Reset overrides enable, sample_en, epoch and dump_ready in the same cycle.
REQ-032 Reset asserted mid-epoch or with a pending dump discards everything. The first cycle after reset release is IDLE.

Verification
REQ-033 Default params, enable=1, 1023 samples data=3'b011 (+7), tap_code=3'b111, epoch on sample 1023 -> next cycle dump_valid=1, each tap=7161.
REQ-034 Same stimulus, tap_code=3'b010, data=3'b100 (-1) -> taps {+1023, -1023, +1023} per tap index {0, 1, 2}, i.e. tap0=+1023, tap1=-1023, tap2=+1023.
REQ-035 ACC_WIDTH=8, 20 samples of +7 then epoch -> each tap=127, dump_sat=3'b111. The next epoch of 1 sample of +1 gives 1 with dump_sat=0.
REQ-036 dump_ready=0, three consecutive epochs -> first result held, overrun=1, overrun_count=2. dump_ready=1 during the 4th epoch cycle -> 4th result loads and dump_valid stays 1.
REQ-037 enable dropped after 500 samples, then raised, then 10 samples of +1 and epoch -> dump=10 per tap. A pending earlier dump is preserved through the enable drop.
REQ-038 reset asserted with dump_valid=1 and overrun_count=5 -> next cycle all outputs 0. Samples in the reset cycle are not accumulated.
